lfsr32_checker: RTL and testbench

LFSR32_CHECKER -- requirements
Module: lfsr32_checker

---
 rtl/lfsr32_checker.sv | 133 +++++++++++++
 tb/tb_lfsr32_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr32_checker.sv
// Receive-side checker for a 32-bit Galois LFSR stream: hunts for a seed, confirms
// a run of matching words before declaring lock, then flywheels and counts bit errors.
module lfsr32_checker #(
   parameter int SYNC_COUNT = 4,
   parameter int LOSS_COUNT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [31:0] din,
   input  logic        clear_cnt,
   output logic        locked,
   output logic        error,
   output logic [15:0] err_cnt
);

   localparam int SCW = $clog2(SYNC_COUNT + 1);
   localparam int LCW = $clog2(LOSS_COUNT + 1);
   localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_COUNT - 1);
   localparam logic [LCW-1:0] LOSS_LAST = LCW'(LOSS_COUNT - 1);

   typedef enum logic [1:0] {
      HUNT,
      SYNC,
      LOCKED
   } state_t;

   state_t          r_state;
   logic [31:0]     r_exp;
   logic [SCW-1:0]  r_syncCnt;
   logic [LCW-1:0]  r_lossCnt;
   logic            r_locked;
   logic            r_error;
   logic [15:0]     r_errCnt;

   logic [31:0]     w_nextDin;
   logic [31:0]     w_nextExp;
   logic            w_match;
   logic            w_zero;
   logic            w_syncDone;
   logic            w_lossDone;
   logic            w_cntFull;

   // One step of the generator's Galois register (taps at bits 31, 21, 1, 0).
   function automatic logic [31:0] lfsrNext(input logic [31:0] q);
      logic [31:0] n;
      n     = q >> 1;
      n[31] = q[0];
      n[21] = q[22] ^ q[0];
      n[1]  = q[2] ^ q[0];
      n[0]  = q[1] ^ q[0];
      return n;
   endfunction

   assign w_nextDin  = lfsrNext(din);
   assign w_nextExp  = lfsrNext(r_exp);
   assign w_match    = (din == r_exp);
   assign w_zero     = (din == 32'd0);
   assign w_syncDone = (r_syncCnt == SYNC_LAST);
   assign w_lossDone = (r_lossCnt == LOSS_LAST);
   assign w_cntFull  = (r_errCnt == 16'hFFFF);

   assign locked  = r_locked;
   assign error   = r_error;
   assign err_cnt = r_errCnt;

   // Single state machine; locked/error/err_cnt are registered alongside the state.
   // While locked, exp advances from its own value so corrupted words never reseed it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= HUNT;
         r_exp     <= '0;
         r_syncCnt <= '0;
         r_lossCnt <= '0;
         r_locked  <= 1'b0;
         r_error   <= 1'b0;
         r_errCnt  <= '0;
      end else begin
         r_error <= 1'b0;
         if (clear_cnt) begin
            r_errCnt <= '0;
         end
         if (valid) begin
            case (r_state)
               HUNT: begin
                  if (!w_zero) begin
                     r_exp     <= w_nextDin;
                     r_syncCnt <= '0;
                     r_state   <= SYNC;
                  end
               end
               SYNC: begin
                  if (w_match) begin
                     r_exp     <= w_nextDin;
                     r_syncCnt <= r_syncCnt + SCW'(1);
                     if (w_syncDone) begin
                        r_state   <= LOCKED;
                        r_locked  <= 1'b1;
                        r_lossCnt <= '0;
                     end
                  end else if (!w_zero) begin
                     r_exp     <= w_nextDin;
                     r_syncCnt <= '0;
                  end else begin
                     r_state <= HUNT;
                  end
               end
               LOCKED: begin
                  r_exp <= w_nextExp;
                  if (w_match) begin
                     r_lossCnt <= '0;
                  end else begin
                     r_error   <= 1'b1;
                     r_lossCnt <= r_lossCnt + LCW'(1);
                     if (!clear_cnt && !w_cntFull) begin
                        r_errCnt <= r_errCnt + 16'd1;
                     end
                     if (w_lossDone) begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_state  <= HUNT;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr32_checker.sv
// Scoreboard bench: two checkers (normal and effectively unlosable lock) share one stimulus
// stream; a reference model predicts their outputs and a monitor compares every cycle.
module tb_lfsr32_checker;

   localparam int SYNC_N = 4;
   localparam int LOSS_N0 = 3;
   localparam int LOSS_N1 = 100000;

   logic        clk;
   logic        reset;
   logic        valid;
   logic [31:0] din;
   logic        clear_cnt;
   logic        locked0, error0, locked1, error1;
   logic [15:0] errCnt0, errCnt1;

   typedef struct packed {
      logic        lk0;
      logic        er0;
      logic [15:0] c0;
      logic        lk1;
      logic        er1;
      logic [15:0] c1;
   } expect_t;

   expect_t     sb[$];
   int          checks = 0;
   int          failures = 0;

   // Model state per instance: run = -1 while hunting, else matches since last seed.
   logic [31:0] mExp[2];
   int          mRun[2];
   int          mMiss[2];
   logic        mLocked[2];
   logic        mErr[2];
   int          mCnt[2];
   int          lossLimit[2];
   logic [31:0] gen;

   lfsr32_checker #(.SYNC_COUNT(SYNC_N), .LOSS_COUNT(LOSS_N0)) u_dut (
      .clk(clk), .reset(reset), .valid(valid), .din(din), .clear_cnt(clear_cnt),
      .locked(locked0), .error(error0), .err_cnt(errCnt0)
   );

   lfsr32_checker #(.SYNC_COUNT(SYNC_N), .LOSS_COUNT(LOSS_N1)) u_sat (
      .clk(clk), .reset(reset), .valid(valid), .din(din), .clear_cnt(clear_cnt),
      .locked(locked1), .error(error1), .err_cnt(errCnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Galois step written as shift plus feedback mask.
   function automatic logic [31:0] nx(input logic [31:0] q);
      return (q >> 1) ^ (q[0] ? 32'h80200003 : 32'h0);
   endfunction

   task automatic modelStep(input int k, input logic v, input logic [31:0] d,
                            input logic c, input logic r);
      if (r) begin
         mExp[k] = '0; mRun[k] = -1; mMiss[k] = 0;
         mLocked[k] = 1'b0; mErr[k] = 1'b0; mCnt[k] = 0;
         return;
      end
      mErr[k] = 1'b0;
      if (c) mCnt[k] = 0;
      if (!v) return;
      if (mLocked[k]) begin
         if (d == mExp[k]) begin
            mMiss[k] = 0;
         end else begin
            mErr[k] = 1'b1;
            if (!c && mCnt[k] < 65535) mCnt[k] = mCnt[k] + 1;
            mMiss[k] = mMiss[k] + 1;
            if (mMiss[k] == lossLimit[k]) begin
               mLocked[k] = 1'b0;
               mRun[k] = -1;
            end
         end
         mExp[k] = nx(mExp[k]);
      end else if (mRun[k] < 0) begin
         if (d != 0) begin
            mExp[k] = nx(d);
            mRun[k] = 0;
         end
      end else if (d == mExp[k]) begin
         mExp[k] = nx(d);
         mRun[k] = mRun[k] + 1;
         if (mRun[k] == SYNC_N) begin
            mLocked[k] = 1'b1;
            mMiss[k] = 0;
         end
      end else if (d != 0) begin
         mExp[k] = nx(d);
         mRun[k] = 0;
      end else begin
         mRun[k] = -1;
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d,
                                input logic c, input logic r);
      expect_t e;
      @(negedge clk);
      valid = v; din = d; clear_cnt = c; reset = r;
      modelStep(0, v, d, c, r);
      modelStep(1, v, d, c, r);
      e.lk0 = mLocked[0]; e.er0 = mErr[0]; e.c0 = 16'(mCnt[0]);
      e.lk1 = mLocked[1]; e.er1 = mErr[1]; e.c1 = 16'(mCnt[1]);
      sb.push_back(e);
   endtask

   task automatic sendGood(input logic c = 1'b0);
      applyStimulus(1'b1, gen, c, 1'b0);
      gen = nx(gen);
   endtask

   task automatic sendBad(input logic c = 1'b0);
      applyStimulus(1'b1, gen ^ 32'h1, c, 1'b0);
      gen = nx(gen);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle after a stimulus cycle, so pop one entry per edge.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("locked0", {15'd0, locked0}, {15'd0, e.lk0});
            checkOutput("error0",  {15'd0, error0},  {15'd0, e.er0});
            checkOutput("errCnt0", errCnt0, e.c0);
            checkOutput("locked1", {15'd0, locked1}, {15'd0, e.lk1});
            checkOutput("error1",  {15'd0, error1},  {15'd0, e.er1});
            checkOutput("errCnt1", errCnt1, e.c1);
         end
      end
   end

   initial begin
      logic [31:0] word;
      int          sel;
      lossLimit[0] = LOSS_N0;
      lossLimit[1] = LOSS_N1;
      reset = 1'b1; valid = 1'b0; din = '0; clear_cnt = 1'b0;
      for (int k = 0; k < 2; k++) modelStep(k, 1'b0, '0, 1'b0, 1'b1);

      // Reset, then lock on the reference sequence starting at 1.
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      gen = 32'h00000001;
      repeat (5) sendGood();
      repeat (3) sendGood();

      // Single corrupted word while locked.
      sendBad();
      repeat (4) sendGood();

      // Loss of lock, then relock from a fresh seed.
      repeat (3) sendBad();
      repeat (6) sendGood();

      // Zeros while hunting, then a gapped sequence.
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      repeat (10) applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
      gen = 32'h00000001;
      repeat (5) begin
         sendGood();
         repeat (2) applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
      end
      sendGood();

      // Build err_cnt to 5 (instance 0 errors are separated by good words), then clear with a mismatch.
      repeat (5) begin
         sendBad();
         sendGood();
      end
      sendBad(1'b1);
      repeat (2) sendGood();

      // Saturation on the instance that never loses lock, then reset while locked.
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      gen = 32'h1234ABCD;
      repeat (5) sendGood();
      repeat (65540) sendBad();
      repeat (2) sendGood();
      applyStimulus(1'b1, gen ^ 32'h1, 1'b1, 1'b1);
      gen = nx(gen);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);

      // Randomized traffic mixing good, corrupted, zero and arbitrary words with gaps and clears.
      gen = 32'hCAFEF00D;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3, 0) == 0) begin
            applyStimulus(1'b0, $urandom, ($urandom_range(49, 0) == 0), 1'b0);
         end else begin
            sel = $urandom_range(99, 0);
            if (sel < 70)      word = gen;
            else if (sel < 85) word = gen ^ (32'h1 << $urandom_range(31, 0));
            else if (sel < 93) word = 32'h0;
            else               word = $urandom;
            applyStimulus(1'b1, word, ($urandom_range(49, 0) == 0),
                          ($urandom_range(499, 0) == 0));
            gen = nx(gen);
         end
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
